// File: rtl/fsm_cov_pkg.sv
// Shared definitions for the FSM coverage monitor: default parameters,
// the monitored FSM's state encodings and its legal-transition mask.
package fsm_cov_pkg;

    localparam int DEF_STATE_W    = 3;
    localparam int DEF_NUM_STATES = 6;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_HOME       = 0;
    localparam int DEF_TRANS_W    = DEF_NUM_STATES * DEF_NUM_STATES;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_PROC   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } fsm_state_e;

    function automatic logic [DEF_TRANS_W-1:0] trans_bit(input fsm_state_e from_st,
                                                         input fsm_state_e to_st);
        int idx;
        idx = int'(from_st) * DEF_NUM_STATES + int'(to_st);
        return {{(DEF_TRANS_W-1){1'b0}}, 1'b1} << idx;
    endfunction

    // ERROR->ERROR is a dwell, never a transition, so "any->ERROR" excludes it.
    localparam logic [DEF_TRANS_W-1:0] DEF_LEGAL =
          trans_bit(ST_IDLE,   ST_WAIT)
        | trans_bit(ST_WAIT,   ST_ACTIVE)
        | trans_bit(ST_ACTIVE, ST_PROC)
        | trans_bit(ST_PROC,   ST_DONE)
        | trans_bit(ST_DONE,   ST_IDLE)
        | trans_bit(ST_IDLE,   ST_ACTIVE)
        | trans_bit(ST_ACTIVE, ST_WAIT)
        | trans_bit(ST_IDLE,   ST_ERROR)
        | trans_bit(ST_WAIT,   ST_ERROR)
        | trans_bit(ST_ACTIVE, ST_ERROR)
        | trans_bit(ST_PROC,   ST_ERROR)
        | trans_bit(ST_DONE,   ST_ERROR)
        | trans_bit(ST_ERROR,  ST_IDLE);

endpackage

// File: rtl/fsm_coverage_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clr together with inc
// loads 1, which lets a run counter restart at one in a single cycle.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_V  = {W{1'b1}};
    localparam logic [W-1:0] ZERO_V = {W{1'b0}};
    localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};

    // Counter register: clear/restart has priority, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= ZERO_V;
        end else if (clr) begin
            q <= inc ? ONE_V : ZERO_V;
        end else if (inc && (q != MAX_V)) begin
            q <= q + ONE_V;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fsm_coverage_monitor.sv
// Observes a sampled FSM state stream and collects state/transition coverage,
// per-state entry counts and longest dwell runs, loop count and illegal moves.
module fsm_coverage_monitor
    import fsm_cov_pkg::*;
#(
    parameter int STATE_W    = DEF_STATE_W,
    parameter int NUM_STATES = DEF_NUM_STATES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int HOME       = DEF_HOME,
    parameter logic [NUM_STATES*NUM_STATES-1:0] LEGAL_TRANS = DEF_LEGAL
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [STATE_W-1:0]               state_i,
    input  logic                             sample_en_i,
    input  logic                             clear_i,
    input  logic [STATE_W-1:0]               rd_idx_i,
    output logic [NUM_STATES-1:0]            state_hit_o,
    output logic [NUM_STATES*NUM_STATES-1:0] trans_hit_o,
    output logic [CNT_W-1:0]                 rd_count_o,
    output logic [CNT_W-1:0]                 rd_dwell_o,
    output logic [CNT_W-1:0]                 loops_o,
    output logic                             covered_o,
    output logic                             illegal_o,
    output logic                             illegal_seen_o,
    output logic [2*STATE_W-1:0]             first_illegal_o,
    output logic                             oob_seen_o
);

    localparam int TW = NUM_STATES * NUM_STATES;
    localparam logic [STATE_W:0]   NUM_S   = (STATE_W+1)'(NUM_STATES);
    localparam logic [STATE_W-1:0] HOME_S  = STATE_W'(HOME);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [STATE_W-1:0]    prev_r;
    logic                  prev_valid_r;
    logic [CNT_W-1:0]      max_dwell_r [NUM_STATES];
    logic [CNT_W-1:0]      count_s     [NUM_STATES];
    logic [CNT_W-1:0]      run_s;
    logic [CNT_W-1:0]      run_next_s;
    logic [NUM_STATES-1:0] state_oh_s;
    logic [NUM_STATES-1:0] prev_oh_s;
    logic [TW-1:0]         trans_oh_s;
    logic                  in_range_s;
    logic                  valid_s;
    logic                  entry_s;
    logic                  trans_s;
    logic                  legal_s;
    logic                  illegal_s;

    assign in_range_s = ({1'b0, state_i} < NUM_S);
    assign valid_s    = sample_en_i && in_range_s && !clear_i;
    assign trans_s    = valid_s && prev_valid_r && (state_i != prev_r);
    assign entry_s    = valid_s && !(prev_valid_r && (state_i == prev_r));
    assign legal_s    = trans_s && (|(trans_oh_s & LEGAL_TRANS));
    assign illegal_s  = trans_s && !(|(trans_oh_s & LEGAL_TRANS));
    assign covered_o  = (&state_hit_o) && (trans_hit_o == LEGAL_TRANS);

    // One-hot decodes of current/previous state and the candidate transition.
    always_comb begin
        state_oh_s = {NUM_STATES{1'b0}};
        prev_oh_s  = {NUM_STATES{1'b0}};
        trans_oh_s = {TW{1'b0}};
        for (int a = 0; a < NUM_STATES; a++) begin
            state_oh_s[a] = (state_i == STATE_W'(a));
            prev_oh_s[a]  = (prev_r == STATE_W'(a));
        end
        for (int a = 0; a < NUM_STATES; a++) begin
            for (int b = 0; b < NUM_STATES; b++) begin
                trans_oh_s[a*NUM_STATES+b] = prev_oh_s[a] & state_oh_s[b];
            end
        end
    end

    // Run value after this sample, needed the same cycle to update max dwell.
    always_comb begin
        if (entry_s) begin
            run_next_s = CNT_ONE;
        end else if (run_s == CNT_MAX) begin
            run_next_s = run_s;
        end else begin
            run_next_s = run_s + CNT_ONE;
        end
    end

    sat_counter #(.W(CNT_W)) u_run (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_i || entry_s),
        .inc   (valid_s),
        .q     (run_s)
    );

    sat_counter #(.W(CNT_W)) u_loops (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_i),
        .inc   (trans_s && (state_i == HOME_S)),
        .q     (loops_o)
    );

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_count
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clear_i),
            .inc   (entry_s && state_oh_s[g]),
            .q     (count_s[g])
        );
    end

    // Statistics, sticky flags and sample history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r          <= {STATE_W{1'b0}};
            prev_valid_r    <= 1'b0;
            state_hit_o     <= {NUM_STATES{1'b0}};
            trans_hit_o     <= {TW{1'b0}};
            illegal_o       <= 1'b0;
            illegal_seen_o  <= 1'b0;
            first_illegal_o <= {(2*STATE_W){1'b0}};
            oob_seen_o      <= 1'b0;
            for (int s = 0; s < NUM_STATES; s++) max_dwell_r[s] <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            prev_r          <= {STATE_W{1'b0}};
            prev_valid_r    <= 1'b0;
            state_hit_o     <= {NUM_STATES{1'b0}};
            trans_hit_o     <= {TW{1'b0}};
            illegal_o       <= 1'b0;
            illegal_seen_o  <= 1'b0;
            first_illegal_o <= {(2*STATE_W){1'b0}};
            oob_seen_o      <= 1'b0;
            for (int s = 0; s < NUM_STATES; s++) max_dwell_r[s] <= {CNT_W{1'b0}};
        end else begin
            illegal_o <= illegal_s;
            if (sample_en_i && !in_range_s) begin
                oob_seen_o <= 1'b1;
            end
            if (valid_s) begin
                prev_r       <= state_i;
                prev_valid_r <= 1'b1;
                state_hit_o  <= state_hit_o | state_oh_s;
                for (int s = 0; s < NUM_STATES; s++) begin
                    if (state_oh_s[s] && (run_next_s > max_dwell_r[s])) begin
                        max_dwell_r[s] <= run_next_s;
                    end
                end
            end
            if (legal_s) begin
                trans_hit_o <= trans_hit_o | trans_oh_s;
            end
            if (illegal_s) begin
                illegal_seen_o <= 1'b1;
                if (!illegal_seen_o) begin
                    first_illegal_o <= {prev_r, state_i};
                end
            end
        end
    end

    // Per-state readout; indices beyond the legal range read as zero.
    always_comb begin
        rd_count_o = {CNT_W{1'b0}};
        rd_dwell_o = {CNT_W{1'b0}};
        for (int s = 0; s < NUM_STATES; s++) begin
            rd_count_o = (rd_idx_i == STATE_W'(s)) ? count_s[s]     : rd_count_o;
            rd_dwell_o = (rd_idx_i == STATE_W'(s)) ? max_dwell_r[s] : rd_dwell_o;
        end
    end

endmodule
